// File: rtl/corr_pkg.sv
// Shared constants and sequencer state encoding for the 512-lag correlator.
package corr_pkg;
  localparam int CORR_ADDR_W  = 9;
  localparam int CORR_DATA_W  = 32;
  localparam int CORR_INT_W   = 16;
  localparam int CORR_OFIFO_D = 4;

  localparam int N      = 2 ** CORR_ADDR_W;
  localparam int GAP    = N + 1;
  localparam int RD_LAT = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    CLR_WAIT,
    ACC,
    ACC_WAIT,
    RD,
    RD_DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/corr_seq_ctrl_if.sv
// Result stream port: lag sums leave the sequencer through this ready/valid bundle.
interface corr_seq_ctrl_if
  import corr_pkg::*;
#(
  parameter int ADDR_W = CORR_ADDR_W,
  parameter int DATA_W = CORR_DATA_W
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_lag;
  logic              out_last;

  modport master (output out_valid, out_data, out_lag, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_lag, out_last, output out_ready);
endinterface

// File: rtl/corr_ofifo.sv
// Small register FIFO that absorbs consumer backpressure during readout.
module corr_ofifo
  import corr_pkg::*;
#(
  parameter int DEPTH = CORR_OFIFO_D,
  parameter int WIDTH = CORR_DATA_W + CORR_ADDR_W + 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && (r_count != CNT_W'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  // Storage is reset so the output bundle reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) r_rdPtr <= r_rdPtr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_data  = r_mem[r_rdPtr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;
endmodule

// File: rtl/corr_seq_ctrl.sv
// Run sequencer for the correlator MAC bank: clear, integrate n_int samples,
// stream all lag sums out, then pulse done.
module corr_seq_ctrl
  import corr_pkg::*;
#(
  parameter int ADDR_W  = CORR_ADDR_W,
  parameter int DATA_W  = CORR_DATA_W,
  parameter int INT_W   = CORR_INT_W,
  parameter int OFIFO_D = CORR_OFIFO_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [INT_W-1:0]  n_int,
  input  logic              smp_valid,
  output logic              smp_ready,
  output logic              mac_clr,
  output logic              mac_sin,
  output logic              mac_read,
  output logic [ADDR_W-1:0] mac_raddr,
  input  logic [DATA_W-1:0] mac_rdata,
  output logic              busy,
  output logic              done,
  corr_seq_ctrl_if.master   out_if
);
  localparam int CNT_W = $clog2(GAP);
  localparam int OCC_W = $clog2(OFIFO_D) + 1;
  localparam int SUM_W = OCC_W + 1;
  localparam int FW    = DATA_W + ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            r_state;
  logic [INT_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_prime;
  logic              r_v1;
  logic              r_v2;
  logic [ADDR_W-1:0] r_lag1;
  logic [ADDR_W-1:0] r_lag2;

  logic              w_fire;
  logic              w_issue;
  logic              w_pop;
  logic              w_drainDone;
  logic [CNT_W-1:0]  w_cntNext;
  logic [OCC_W-1:0]  w_occ;
  logic [SUM_W-1:0]  w_used;
  logic [FW-1:0]     w_fifoIn;
  logic [FW-1:0]     w_fifoOut;
  logic              w_fifoValid;

  assign w_fire    = (r_state == ACC) && smp_valid;
  assign w_cntNext = r_cnt - CNT_W'(1);

  // Credit gate: the bank pipeline cannot stall, so an address is only issued
  // when every word already in flight is guaranteed a FIFO slot.
  assign w_used  = SUM_W'(w_occ) + SUM_W'(r_v1) + SUM_W'(r_v2);
  assign w_issue = (r_state == RD) && !r_prime && (w_used < SUM_W'(OFIFO_D));

  assign w_pop       = w_fifoValid && out_if.out_ready;
  assign w_drainDone = !r_v1 && !r_v2 &&
                       ((w_occ == '0) || ((w_occ == OCC_W'(1)) && w_pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_raddr <= '0;
      r_prime <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_rem   <= n_int;
          r_state <= CLR;
        end
        CLR: begin
          r_cnt   <= CNT_W'(GAP - 1);
          r_state <= CLR_WAIT;
        end
        CLR_WAIT, ACC_WAIT: begin
          r_cnt <= w_cntNext;
          if (w_cntNext == '0) begin
            r_state <= (r_rem != '0) ? ACC : RD;
            r_raddr <= '0;
            r_prime <= 1'b1;
          end
        end
        ACC: if (w_fire) begin
          r_rem   <= r_rem - INT_W'(1);
          r_cnt   <= CNT_W'(GAP - 1);
          r_state <= ACC_WAIT;
        end
        RD: begin
          r_prime <= 1'b0;
          if (w_issue) begin
            if (r_raddr == LAST_ADDR) r_state <= RD_DRAIN;
            else                      r_raddr <= r_raddr + ADDR_W'(1);
          end
        end
        RD_DRAIN: if (w_drainDone) r_state <= DONE;
        DONE:     r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  // Tags ride alongside the two-cycle bank read so only issued words are captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_lag1 <= '0;
      r_lag2 <= '0;
    end else begin
      r_v1   <= w_issue;
      r_lag1 <= r_raddr;
      r_v2   <= r_v1;
      r_lag2 <= r_lag1;
    end
  end

  assign w_fifoIn = {mac_rdata, r_lag2, (r_lag2 == LAST_ADDR)};

  corr_ofifo #(
    .DEPTH (OFIFO_D),
    .WIDTH (FW)
  ) u_ofifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_v2),
    .i_data  (w_fifoIn),
    .i_pop   (w_pop),
    .o_data  (w_fifoOut),
    .o_valid (w_fifoValid),
    .o_count (w_occ)
  );

  assign out_if.out_valid = w_fifoValid;
  assign out_if.out_data  = w_fifoOut[FW-1 -: DATA_W];
  assign out_if.out_lag   = w_fifoOut[ADDR_W:1];
  assign out_if.out_last  = w_fifoOut[0];

  assign smp_ready = w_fire;
  assign mac_sin   = w_fire;
  assign mac_clr   = (r_state == CLR);
  assign mac_read  = (r_state == RD);
  assign mac_raddr = r_raddr;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
endmodule

// File: tb/tb_corr_seq_ctrl.sv
// Directed bench for corr_seq_ctrl with a behavioural MAC bank whose sweep adds smpA*lag.
module tb_corr_seq_ctrl;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int IW = 16;
  localparam int NN = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] n_int = '0;
  logic          smp_valid = 1'b0;
  logic [15:0]   smpA = '0;
  logic          out_ready = 1'b0;
  logic          smp_ready, mac_clr, mac_sin, mac_read, busy, done;
  logic [AW-1:0] mac_raddr;
  logic [DW-1:0] mac_rdata;
  logic [DW-1:0] ram [NN];
  logic [DW-1:0] rdPipe;
  logic [57:0]   allOut;

  corr_seq_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) oif ();
  assign oif.out_ready = out_ready;

  corr_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .n_int     (n_int),
    .smp_valid (smp_valid),
    .smp_ready (smp_ready),
    .mac_clr   (mac_clr),
    .mac_sin   (mac_sin),
    .mac_read  (mac_read),
    .mac_raddr (mac_raddr),
    .mac_rdata (mac_rdata),
    .busy      (busy),
    .done      (done),
    .out_if    (oif.master)
  );

  always #5 clk = ~clk;

  // Bank model: clear zeroes, a sweep adds smpA*lag, reads arrive two cycles later.
  always @(posedge clk) begin
    if (mac_clr) for (int i = 0; i < NN; i++) ram[i] <= '0;
    if (mac_sin) for (int i = 0; i < NN; i++) ram[i] <= ram[i] + DW'(smpA) * DW'(i);
    rdPipe    <= ram[mac_raddr];
    mac_rdata <= rdPipe;
  end

  assign allOut = {smp_ready, mac_clr, mac_sin, mac_read, mac_raddr, oif.out_valid,
                   oif.out_data, oif.out_lag, oif.out_last, busy, done};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nClr, nSin, nReadyPulse, badSin, spacingViol, stallViol, nDone;
  int clrCyc, firstReadCyc, lastPulse, doneCyc, lastBeatCyc;
  int nBadLag, nBadData, nBadLast, nGap;
  int sinCyc[$];
  int bCyc[$];
  logic [AW-1:0] bLag[$];
  logic [DW-1:0] bData[$];
  bit bLast[$];
  logic sReady, sClr, sBusy;
  bit pStall;
  logic [DW-1:0] pData;
  logic [AW-1:0] pLag;
  logic pLast;

  task automatic clearStats();
    nClr = 0; nSin = 0; nReadyPulse = 0; badSin = 0; spacingViol = 0; stallViol = 0;
    nDone = 0; clrCyc = -1; firstReadCyc = -1; lastPulse = -100000; doneCyc = -1;
    sinCyc.delete(); bCyc.delete(); bLag.delete(); bData.delete(); bLast.delete();
    pStall = 0;
  endtask

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    sReady = smp_ready;
    sClr   = mac_clr;
    sBusy  = busy;
    if (mac_clr) begin nClr++; clrCyc = cyc; end
    if (smp_ready) nReadyPulse++;
    if (mac_sin) begin nSin++; sinCyc.push_back(cyc); end
    if ((smp_ready !== mac_sin) || (mac_sin && !smp_valid)) badSin++;
    if (mac_read && firstReadCyc < 0) firstReadCyc = cyc;
    if ((mac_clr || mac_sin || mac_read) && cyc > lastPulse && cyc < lastPulse + 513) spacingViol++;
    if (mac_read && (mac_clr || mac_sin)) spacingViol++;
    if (mac_clr || mac_sin) lastPulse = cyc;
    if (pStall && (!oif.out_valid || oif.out_data !== pData || oif.out_lag !== pLag ||
                   oif.out_last !== pLast)) stallViol++;
    pStall = oif.out_valid && !out_ready;
    pData = oif.out_data; pLag = oif.out_lag; pLast = oif.out_last;
    if (oif.out_valid && out_ready) begin
      bCyc.push_back(cyc); bLag.push_back(oif.out_lag);
      bData.push_back(oif.out_data); bLast.push_back(oif.out_last);
    end
    if (done) begin nDone++; doneCyc = cyc; end
    @(posedge clk);
    #1;
  endtask

  task automatic runToDone(input int budget, input bit randReady, input bit randValid,
                           input int startAt, output bit timedOut);
    timedOut = 1'b1;
    for (int k = 0; k < budget; k++) begin
      out_ready = randReady ? ($urandom_range(0, 99) < 30) : 1'b1;
      if (randValid) smp_valid = ($urandom_range(0, 3) == 0);
      start = (k == startAt);
      tick();
      if (nDone > 0) begin timedOut = 1'b0; break; end
    end
    start = 1'b0;
  endtask

  task automatic summarizeBeats(input int mult);
    nBadLag = 0; nBadData = 0; nBadLast = 0; nGap = 0;
    for (int k = 0; k < bLag.size(); k++) begin
      if (bLag[k] !== AW'(k)) nBadLag++;
      if (bData[k] !== DW'(k * mult)) nBadData++;
      if (bLast[k] !== (k == NN - 1)) nBadLast++;
      if (k > 0 && bCyc[k] != bCyc[k-1] + 1) nGap++;
    end
    lastBeatCyc = (bCyc.size() > 0) ? bCyc[bCyc.size()-1] : -10;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (allOut !== '0) begin errors++; $display("[TB] FAIL reset_outputs: got %h want 0", allOut); end
    rst_n = 1'b1;
    tick(); tick();
    checks++; if (allOut !== '0) begin errors++; $display("[TB] FAIL idle_outputs: got %h want 0", allOut); end
  endtask

  task automatic test_clear_only();
    bit to;
    clearStats();
    n_int = 16'd0; smp_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    tick();
    checks++; if (sReady !== 1'b0) begin errors++; $display("[TB] FAIL start_smp_ready: got %b want 0", sReady); end
    checks++; if (sBusy !== 1'b0) begin errors++; $display("[TB] FAIL busy_start_cycle: got %b want 0", sBusy); end
    start = 1'b0;
    tick();
    checks++; if ({sClr, sBusy} !== 2'b11) begin errors++; $display("[TB] FAIL clr_pulse: got clr,busy=%b want 11", {sClr, sBusy}); end
    tick();
    checks++; if (sClr !== 1'b0) begin errors++; $display("[TB] FAIL clr_width: got %b want 0", sClr); end
    runToDone(3000, 1'b0, 1'b0, -1, to);
    summarizeBeats(0);
    checks++; if (to) begin errors++; $display("[TB] FAIL n0_timeout: got no done want done"); end
    checks++; if (nClr != 1 || nSin != 0) begin errors++; $display("[TB] FAIL n0_pulses: got clr=%0d sin=%0d want 1,0", nClr, nSin); end
    checks++; if (spacingViol != 0) begin errors++; $display("[TB] FAIL n0_spacing: got %0d violations want 0", spacingViol); end
    checks++; if (firstReadCyc - clrCyc < 513 || firstReadCyc - clrCyc > 514) begin
      errors++; $display("[TB] FAIL n0_clr_to_read: got %0d want 513..514", firstReadCyc - clrCyc); end
    checks++; if (bLag.size() != NN) begin errors++; $display("[TB] FAIL n0_beats: got %0d want %0d", bLag.size(), NN); end
    checks++; if (nBadLag + nBadData + nBadLast != 0) begin
      errors++; $display("[TB] FAIL n0_words: got bad lag/data/last %0d/%0d/%0d want 0", nBadLag, nBadData, nBadLast); end
    checks++; if (nGap != 0) begin errors++; $display("[TB] FAIL n0_throughput: got %0d gaps want 0", nGap); end
    checks++; if (doneCyc != lastBeatCyc + 1) begin errors++; $display("[TB] FAIL n0_done_time: got %0d want %0d", doneCyc, lastBeatCyc + 1); end
    tick();
    checks++; if (sBusy !== 1'b0 || nDone != 1) begin errors++; $display("[TB] FAIL n0_end: got busy=%b dones=%0d want 0,1", sBusy, nDone); end
  endtask

  task automatic test_integrate();
    bit to;
    clearStats();
    n_int = 16'd3; smpA = 16'd7; smp_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    runToDone(4000, 1'b0, 1'b0, -1, to);
    summarizeBeats(21);
    checks++; if (to) begin errors++; $display("[TB] FAIL n3_timeout: got no done want done"); end
    checks++; if (nSin != 3 || nReadyPulse != 3 || badSin != 0) begin
      errors++; $display("[TB] FAIL n3_sin: got sin=%0d ready=%0d bad=%0d want 3,3,0", nSin, nReadyPulse, badSin); end
    if (sinCyc.size() == 3) begin
      checks++; if (sinCyc[0] - clrCyc < 513 || sinCyc[0] - clrCyc > 514) begin
        errors++; $display("[TB] FAIL n3_clr_to_sin: got %0d want 513..514", sinCyc[0] - clrCyc); end
      checks++; if (sinCyc[1] - sinCyc[0] != 513 || sinCyc[2] - sinCyc[1] != 513) begin
        errors++; $display("[TB] FAIL n3_sin_gap: got %0d,%0d want 513,513", sinCyc[1] - sinCyc[0], sinCyc[2] - sinCyc[1]); end
      checks++; if (firstReadCyc - sinCyc[2] < 513 || firstReadCyc - sinCyc[2] > 514) begin
        errors++; $display("[TB] FAIL n3_sin_to_read: got %0d want 513..514", firstReadCyc - sinCyc[2]); end
    end
    checks++; if (spacingViol != 0) begin errors++; $display("[TB] FAIL n3_spacing: got %0d violations want 0", spacingViol); end
    checks++; if (bLag.size() != NN) begin errors++; $display("[TB] FAIL n3_beats: got %0d want %0d", bLag.size(), NN); end
    checks++; if (nBadData != 0) begin errors++; $display("[TB] FAIL n3_data: got %0d bad words want 0", nBadData); end
    checks++; if (nBadLag + nBadLast != 0) begin errors++; $display("[TB] FAIL n3_lag_last: got %0d/%0d bad want 0", nBadLag, nBadLast); end
    checks++; if (nGap != 0) begin errors++; $display("[TB] FAIL n3_throughput: got %0d gaps want 0", nGap); end
    checks++; if (doneCyc != lastBeatCyc + 1) begin errors++; $display("[TB] FAIL n3_done_time: got %0d want %0d", doneCyc, lastBeatCyc + 1); end
    tick();
    checks++; if (sBusy !== 1'b0) begin errors++; $display("[TB] FAIL n3_busy_fall: got %b want 0", sBusy); end
  endtask

  task automatic test_backpressure();
    bit to;
    clearStats();
    n_int = 16'd1; smpA = 16'd5; smp_valid = 1'b0; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n_int = 16'd5;
    runToDone(6000, 1'b1, 1'b1, 1200, to);
    summarizeBeats(5);
    checks++; if (to) begin errors++; $display("[TB] FAIL bp_timeout: got no done want done"); end
    checks++; if (nClr != 1) begin errors++; $display("[TB] FAIL bp_start_ignored: got %0d clears want 1", nClr); end
    checks++; if (nSin != 1 || nReadyPulse != 1 || badSin != 0) begin
      errors++; $display("[TB] FAIL bp_sample: got sin=%0d ready=%0d bad=%0d want 1,1,0", nSin, nReadyPulse, badSin); end
    checks++; if (spacingViol != 0) begin errors++; $display("[TB] FAIL bp_spacing: got %0d violations want 0", spacingViol); end
    checks++; if (bLag.size() != NN) begin errors++; $display("[TB] FAIL bp_beats: got %0d want %0d", bLag.size(), NN); end
    checks++; if (nBadLag != 0) begin errors++; $display("[TB] FAIL bp_order: got %0d bad lags want 0", nBadLag); end
    checks++; if (nBadData + nBadLast != 0) begin errors++; $display("[TB] FAIL bp_data: got %0d/%0d bad want 0", nBadData, nBadLast); end
    checks++; if (stallViol != 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d changes while stalled want 0", stallViol); end
    checks++; if (doneCyc != lastBeatCyc + 1) begin errors++; $display("[TB] FAIL bp_done_time: got %0d want %0d", doneCyc, lastBeatCyc + 1); end
    tick();
    checks++; if (nDone != 1) begin errors++; $display("[TB] FAIL bp_done_width: got %0d want 1", nDone); end
  endtask

  task automatic test_reset_midrun();
    bit to;
    clearStats();
    n_int = 16'd2; smpA = 16'd9; smp_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 1200 && nSin == 0; k++) tick();
    repeat (100) tick();
    checks++; if (nSin != 1 || sBusy !== 1'b1) begin errors++; $display("[TB] FAIL rst_precond: got sin=%0d busy=%b want 1,1", nSin, sBusy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (allOut !== '0) begin errors++; $display("[TB] FAIL rst_async: got %h want 0", allOut); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    clearStats();
    n_int = 16'd1; smpA = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    runToDone(3000, 1'b0, 1'b0, -1, to);
    summarizeBeats(3);
    checks++; if (to) begin errors++; $display("[TB] FAIL rerun_timeout: got no done want done"); end
    checks++; if (nClr != 1 || nSin != 1) begin errors++; $display("[TB] FAIL rerun_pulses: got clr=%0d sin=%0d want 1,1", nClr, nSin); end
    checks++; if (bLag.size() != NN) begin errors++; $display("[TB] FAIL rerun_beats: got %0d want %0d", bLag.size(), NN); end
    checks++; if (nBadData + nBadLag + nBadLast != 0) begin
      errors++; $display("[TB] FAIL rerun_words: got bad data/lag/last %0d/%0d/%0d want 0", nBadData, nBadLag, nBadLast); end
    checks++; if (spacingViol != 0) begin errors++; $display("[TB] FAIL rerun_spacing: got %0d violations want 0", spacingViol); end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_clear_only();
    test_integrate();
    test_backpressure();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
